// File: rtl/rx_mux_rr_if.sv
// rx_mux_rr_if: per-port receive FIFO taps plus the shared switch-core side.
// Latency: per-port and shared FIFO dout are valid one cycle after their rd strobe.
// Backpressure: the aggregator stops granting new frames while the shared side is near full.
//
// Signals:
//   rx_ptr_fifo_empty/rd/dout  : per-port descriptor FIFOs (16 bits per port)
//   rx_data_fifo_rd/dout       : per-port byte FIFOs (8 bits per port)
//   sfifo_rd/dout              : shared byte FIFO read side
//   ptr_sfifo_rd/dout/empty    : shared descriptor FIFO read side
interface rx_mux_rr_if #(
  parameter int NUM_PORTS = 4,
  parameter int LEN_W     = 11
);
  logic [NUM_PORTS-1:0]          rx_ptr_fifo_empty;
  logic [NUM_PORTS-1:0]          rx_ptr_fifo_rd;
  logic [16*NUM_PORTS-1:0]       rx_ptr_fifo_dout;
  logic [NUM_PORTS-1:0]          rx_data_fifo_rd;
  logic [8*NUM_PORTS-1:0]        rx_data_fifo_dout;
  logic                          sfifo_rd;
  logic [7:0]                    sfifo_dout;
  logic                          ptr_sfifo_rd;
  logic [NUM_PORTS+LEN_W:0]      ptr_sfifo_dout;
  logic                          ptr_sfifo_empty;

  // Aggregator side.
  modport master (
    input  rx_ptr_fifo_empty, rx_ptr_fifo_dout, rx_data_fifo_dout, sfifo_rd, ptr_sfifo_rd,
    output rx_ptr_fifo_rd, rx_data_fifo_rd, sfifo_dout, ptr_sfifo_dout, ptr_sfifo_empty
  );

  // Per-port queues and switch-core consumer side.
  modport slave (
    output rx_ptr_fifo_empty, rx_ptr_fifo_dout, rx_data_fifo_dout, sfifo_rd, ptr_sfifo_rd,
    input  rx_ptr_fifo_rd, rx_data_fifo_rd, sfifo_dout, ptr_sfifo_dout, ptr_sfifo_empty
  );
endinterface

// File: rtl/rx_mux_rr.sv
// sync_fifo: generic single-clock FIFO with occupancy count.
// Latency: dout registered, valid one cycle after rd; write visible to rd next cycle.
// Backpressure: writes when full and reads when empty are ignored; caller watches full/count.
//
// Ports: clk, rstn, wr/din, rd/dout, empty, full, count (0..2^AW).
module sync_fifo #(
  parameter int DW = 8,
  parameter int AW = 4
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          wr,
  input  logic [DW-1:0] din,
  input  logic          rd,
  output logic [DW-1:0] dout,
  output logic          empty,
  output logic          full,
  output logic [AW:0]   count
);
  logic [DW-1:0] mem [2**AW];
  logic [AW:0]   wr_ptr_q, wr_ptr_d;
  logic [AW:0]   rd_ptr_q, rd_ptr_d;
  logic [DW-1:0] dout_q, dout_d;
  logic          do_wr, do_rd;

  // Extra MSB on the pointers distinguishes full from empty.
  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign count = wr_ptr_q - rd_ptr_q;
  assign dout  = dout_q;
  assign do_wr = wr && !full;
  assign do_rd = rd && !empty;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    dout_d   = dout_q;
    if (do_wr) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_rd) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
      dout_d   = mem[rd_ptr_q[AW-1:0]];
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      dout_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      dout_q   <= dout_d;
    end
  end

  // Storage is not reset; pointers alone define the contents.
  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr_q[AW-1:0]] <= din;
  end
endmodule

// rx_mux_rr: N-port ingress aggregator, whole-frame copy into shared data/descriptor FIFOs.
// Latency: 3 cycles from grant to first data read; 4 non-data cycles per frame.
// Backpressure: no new grant while shared data FIFO is above 2^DATA_AW-MAX_FRAME or descriptor FIFO full.
//
// Ports: clk, rstn (async active-low), bus (rx_mux_rr_if.master),
//        frames_fwd / frames_drop (saturating frame counters).
module rx_mux_rr #(
  parameter int NUM_PORTS   = 4,
  parameter int ARB_MODE    = 0,
  parameter int LEN_W       = 11,
  parameter int STRIP_BYTES = 4,
  parameter int DATA_AW     = 14,
  parameter int PTR_AW      = 5,
  parameter int MAX_FRAME   = 1518
) (
  input  logic        clk,
  input  logic        rstn,
  rx_mux_rr_if.master bus,
  output logic [31:0] frames_fwd,
  output logic [31:0] frames_drop
);
  localparam int PW     = $clog2(NUM_PORTS);
  localparam int DESC_W = 1 + NUM_PORTS + LEN_W;
  localparam logic [DATA_AW:0] BP_LVL  = (DATA_AW+1)'(2**DATA_AW - MAX_FRAME);
  localparam logic [LEN_W-1:0] STRIP_L = LEN_W'(STRIP_BYTES);

  typedef enum logic [2:0] {S_IDLE, S_PTR_LAT, S_PTR_CAP, S_DATA, S_DESC} state_t;

  state_t               state_q, state_d;
  logic [PW-1:0]        gnt_q, gnt_d;
  logic [PW-1:0]        rr_q, rr_d;
  logic [NUM_PORTS-1:0] ptr_rd_q, ptr_rd_d;
  logic [NUM_PORTS-1:0] data_rd_q, data_rd_d;
  logic [LEN_W-1:0]     len_q, len_d;
  logic                 drop_q, drop_d;
  logic [LEN_W-1:0]     rd_cnt_q, rd_cnt_d;
  logic [LEN_W-1:0]     cap_cnt_q, cap_cnt_d;
  logic                 cap_vld_q, cap_vld_d;
  logic [31:0]          fwd_q, fwd_d;
  logic [31:0]          drp_q, drp_d;

  logic                 arb_vld;
  logic [PW-1:0]        arb_idx;
  logic [15:0]          cur_desc;
  logic [7:0]           cur_byte;
  logic [LEN_W-1:0]     cap_len;
  logic                 cap_drop;
  logic [LEN_W-1:0]     fwd_len;
  logic                 bp;
  logic                 sfifo_wr;
  logic                 ptr_wr;
  logic [DATA_AW:0]     sfifo_count;
  logic                 sfifo_empty, sfifo_full;
  logic                 ptr_full;
  logic [PTR_AW:0]      ptr_count;
  logic                 unused_ok;

  function automatic logic [NUM_PORTS-1:0] onehot(input logic [PW-1:0] i);
    return NUM_PORTS'(1) << i;
  endfunction

  assign cur_desc = bus.rx_ptr_fifo_dout[16*gnt_q +: 16];
  assign cur_byte = bus.rx_data_fifo_dout[8*gnt_q +: 8];
  assign cap_len  = cur_desc[LEN_W-1:0];
  assign cap_drop = cur_desc[15] | cur_desc[14] | (cap_len <= STRIP_L);
  assign fwd_len  = len_q - STRIP_L;
  // Threshold leaves room for one worst-case frame, so a granted frame never overflows.
  assign bp       = (sfifo_count > BP_LVL) | ptr_full;

  assign bus.rx_ptr_fifo_rd  = ptr_rd_q;
  assign bus.rx_data_fifo_rd = data_rd_q;
  assign frames_fwd          = fwd_q;
  assign frames_drop         = drp_q;

  // Arbiter: scan from rr_q (round-robin) or from 0 (fixed priority).
  always_comb begin
    int idx;
    arb_vld = 1'b0;
    arb_idx = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      idx = (ARB_MODE == 1) ? i : int'(rr_q) + i;
      if (idx >= NUM_PORTS) idx = idx - NUM_PORTS;
      if (!arb_vld && !bus.rx_ptr_fifo_empty[idx]) begin
        arb_vld = 1'b1;
        arb_idx = idx[PW-1:0];
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    gnt_d     = gnt_q;
    rr_d      = rr_q;
    ptr_rd_d  = '0;
    data_rd_d = '0;
    len_d     = len_q;
    drop_d    = drop_q;
    rd_cnt_d  = rd_cnt_q;
    cap_cnt_d = cap_cnt_q;
    cap_vld_d = |data_rd_q;   // byte on dout is valid the cycle after its read
    fwd_d     = fwd_q;
    drp_d     = drp_q;
    sfifo_wr  = 1'b0;
    ptr_wr    = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (!bp && arb_vld) begin
          gnt_d    = arb_idx;
          ptr_rd_d = onehot(arb_idx);
          state_d  = S_PTR_LAT;
        end
      end
      S_PTR_LAT: begin
        rr_d    = (gnt_q == PW'(NUM_PORTS-1)) ? '0 : gnt_q + 1'b1;
        state_d = S_PTR_CAP;
      end
      S_PTR_CAP: begin
        len_d     = cap_len;
        drop_d    = cap_drop;
        cap_cnt_d = '0;
        if (cap_len == '0) begin
          drp_d   = (drp_q == '1) ? drp_q : drp_q + 1'b1;
          state_d = S_IDLE;
        end else begin
          // First read issues next cycle; rd_cnt counts reads already scheduled.
          data_rd_d = onehot(gnt_q);
          rd_cnt_d  = LEN_W'(1);
          state_d   = S_DATA;
        end
      end
      S_DATA: begin
        if (rd_cnt_q < len_q) begin
          data_rd_d = onehot(gnt_q);
          rd_cnt_d  = rd_cnt_q + 1'b1;
        end
        if (cap_vld_q) begin
          sfifo_wr  = !drop_q && (cap_cnt_q < fwd_len);
          cap_cnt_d = cap_cnt_q + 1'b1;
          if (cap_cnt_q == len_q - 1'b1) state_d = S_DESC;
        end
      end
      S_DESC: begin
        if (!drop_q) begin
          ptr_wr = 1'b1;
          fwd_d  = (fwd_q == '1) ? fwd_q : fwd_q + 1'b1;
        end else begin
          drp_d  = (drp_q == '1) ? drp_q : drp_q + 1'b1;
        end
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q   <= S_IDLE;
      gnt_q     <= '0;
      rr_q      <= '0;
      ptr_rd_q  <= '0;
      data_rd_q <= '0;
      len_q     <= '0;
      drop_q    <= 1'b0;
      rd_cnt_q  <= '0;
      cap_cnt_q <= '0;
      cap_vld_q <= 1'b0;
      fwd_q     <= '0;
      drp_q     <= '0;
    end else begin
      state_q   <= state_d;
      gnt_q     <= gnt_d;
      rr_q      <= rr_d;
      ptr_rd_q  <= ptr_rd_d;
      data_rd_q <= data_rd_d;
      len_q     <= len_d;
      drop_q    <= drop_d;
      rd_cnt_q  <= rd_cnt_d;
      cap_cnt_q <= cap_cnt_d;
      cap_vld_q <= cap_vld_d;
      fwd_q     <= fwd_d;
      drp_q     <= drp_d;
    end
  end

  sync_fifo #(.DW(8), .AW(DATA_AW)) u_sfifo (
    .clk   (clk),
    .rstn  (rstn),
    .wr    (sfifo_wr),
    .din   (cur_byte),
    .rd    (bus.sfifo_rd),
    .dout  (bus.sfifo_dout),
    .empty (sfifo_empty),
    .full  (sfifo_full),
    .count (sfifo_count)
  );

  sync_fifo #(.DW(DESC_W), .AW(PTR_AW)) u_ptr_sfifo (
    .clk   (clk),
    .rstn  (rstn),
    .wr    (ptr_wr),
    .din   ({1'b0, onehot(gnt_q), fwd_len}),
    .rd    (bus.ptr_sfifo_rd),
    .dout  (bus.ptr_sfifo_dout),
    .empty (bus.ptr_sfifo_empty),
    .full  (ptr_full),
    .count (ptr_count)
  );

  // Status outputs and descriptor spare bits that this block does not need.
  assign unused_ok = &{1'b0, sfifo_empty, sfifo_full, ptr_count, cur_desc};
endmodule

// File: tb/tb_rx_mux_rr.sv
// tb_rx_mux_rr: bench for rx_mux_rr with per-port FIFO models and a frame scoreboard.
// Latency: models return dout one cycle after rd, like the real per-port FIFOs.
// Backpressure: the consumer drains the shared FIFOs only when a phase asks for it.
module tb_rx_mux_rr;
  localparam int NP   = 4;
  localparam int LW   = 11;
  localparam int DW_D = 1 + NP + LW;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic [31:0] frames_fwd, frames_drop;

  always #5 clk = ~clk;

  rx_mux_rr_if #(.NUM_PORTS(NP), .LEN_W(LW)) bus ();

  rx_mux_rr #(
    .NUM_PORTS(NP), .ARB_MODE(0), .LEN_W(LW), .STRIP_BYTES(4),
    .DATA_AW(14), .PTR_AW(5), .MAX_FRAME(1518)
  ) dut (
    .clk         (clk),
    .rstn        (rstn),
    .bus         (bus.master),
    .frames_fwd  (frames_fwd),
    .frames_drop (frames_drop)
  );

  // Per-port queue models.
  logic [15:0] pmem [NP][16];
  logic [7:0]  dmem [NP][8192];
  int pwp [NP] = '{default: 0};
  int prp [NP] = '{default: 0};
  int dwp [NP] = '{default: 0};
  int drp [NP] = '{default: 0};

  always @(posedge clk) begin
    for (int i = 0; i < NP; i++) begin
      if (bus.rx_ptr_fifo_rd[i]) begin
        bus.rx_ptr_fifo_dout[16*i +: 16] <= pmem[i][prp[i] % 16];
        prp[i] = prp[i] + 1;
      end
      if (bus.rx_data_fifo_rd[i]) begin
        bus.rx_data_fifo_dout[8*i +: 8] <= dmem[i][drp[i] % 8192];
        drp[i] = drp[i] + 1;
      end
      bus.rx_ptr_fifo_empty[i] <= (prp[i] == pwp[i]);
    end
  end

  int checks = 0;
  int errors = 0;
  int exp_fwd = 0;
  int exp_drop = 0;
  logic [DW_D-1:0] exp_desc [$];
  logic [7:0]      exp_byte [$];

  always @(negedge clk) begin
    if (rstn && (!$onehot0(bus.rx_ptr_fifo_rd) || !$onehot0(bus.rx_data_fifo_rd))) begin
      errors++;
      $display("FAIL strobe_onehot ptr_rd %b data_rd %b required one-hot or zero",
               bus.rx_ptr_fifo_rd, bus.rx_data_fifo_rd);
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual %0h required %0h", name, act, req);
    end
  endtask

  // Load one frame into port p; exp_len is the forwarded length when fwd is set.
  task automatic push_frame(input int p, input logic [1:0] err, input int len,
                            input bit fwd, input int exp_len);
    logic [7:0] b;
    for (int k = 0; k < len; k++) begin
      b = 8'($urandom);
      dmem[p][(dwp[p] + k) % 8192] = b;
      if (fwd && k < exp_len) exp_byte.push_back(b);
    end
    dwp[p] = dwp[p] + len;
    pmem[p][pwp[p] % 16] = {err, 3'b000, LW'(len)};
    if (fwd) begin
      exp_desc.push_back({1'b0, NP'(1) << p, LW'(exp_len)});
      exp_fwd++;
    end else begin
      exp_drop++;
    end
    pwp[p] = pwp[p] + 1;
  endtask

  task automatic wait_done(input int n, input int budget);
    int c = 0;
    while ((frames_fwd + frames_drop) != 32'(n) && c < budget) begin
      @(negedge clk);
      c++;
    end
    check("frames_done", 64'(frames_fwd + frames_drop), 64'(n));
  endtask

  // Pop one descriptor and its bytes from the shared FIFOs and compare.
  task automatic drain_one();
    int c = 0;
    int len;
    int nbad = 0;
    logic [DW_D-1:0] d, e;
    logic [7:0] eb;
    while (bus.ptr_sfifo_empty && c < 2000) begin
      @(negedge clk);
      c++;
    end
    check("desc_avail", 64'(bus.ptr_sfifo_empty), 64'(0));
    if (bus.ptr_sfifo_empty) return;
    bus.ptr_sfifo_rd = 1'b1;
    @(negedge clk);
    bus.ptr_sfifo_rd = 1'b0;
    d = bus.ptr_sfifo_dout;
    e = (exp_desc.size() > 0) ? exp_desc.pop_front() : '1;
    check("desc", 64'(d), 64'(e));
    len = int'(d[LW-1:0]);
    if (len == 0) return;
    bus.sfifo_rd = 1'b1;
    for (int k = 0; k < len; k++) begin
      @(negedge clk);
      if (k == len - 1) bus.sfifo_rd = 1'b0;
      eb = (exp_byte.size() > 0) ? exp_byte.pop_front() : 8'hxx;
      if (bus.sfifo_dout !== eb) nbad++;
    end
    check("frame_bytes_bad", 64'(nbad), 64'(0));
  endtask

  typedef struct {
    int         port;
    logic [1:0] err;
    int         len;
    bit         fwd;
    int         exp_len;
  } vec_t;

  vec_t vt [8];

  initial begin
    int n;
    int c;
    vt[0] = '{port: 0, err: 2'b00, len: 64,   fwd: 1'b1, exp_len: 60};
    vt[1] = '{port: 2, err: 2'b01, len: 100,  fwd: 1'b0, exp_len: 0};
    vt[2] = '{port: 1, err: 2'b00, len: 70,   fwd: 1'b1, exp_len: 66};
    vt[3] = '{port: 3, err: 2'b00, len: 4,    fwd: 1'b0, exp_len: 0};
    vt[4] = '{port: 0, err: 2'b00, len: 0,    fwd: 1'b0, exp_len: 0};
    vt[5] = '{port: 3, err: 2'b10, len: 20,   fwd: 1'b0, exp_len: 0};
    vt[6] = '{port: 1, err: 2'b00, len: 5,    fwd: 1'b1, exp_len: 1};
    vt[7] = '{port: 2, err: 2'b00, len: 1518, fwd: 1'b1, exp_len: 1514};

    bus.sfifo_rd     = 1'b0;
    bus.ptr_sfifo_rd = 1'b0;
    repeat (3) @(negedge clk);
    rstn = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_ptr_rd", 64'(bus.rx_ptr_fifo_rd), 64'(0));
    check("rst_data_rd", 64'(bus.rx_data_fifo_rd), 64'(0));
    check("rst_ptr_empty", 64'(bus.ptr_sfifo_empty), 64'(1));
    check("rst_fwd", 64'(frames_fwd), 64'(0));
    check("rst_drop", 64'(frames_drop), 64'(0));

    // One frame at a time from the vector table.
    for (int i = 0; i < 8; i++) begin
      push_frame(vt[i].port, vt[i].err, vt[i].len, vt[i].fwd, vt[i].exp_len);
      wait_done(exp_fwd + exp_drop, 3000);
      repeat (2) @(negedge clk);
      check("fwd_cnt", 64'(frames_fwd), 64'(exp_fwd));
      check("drop_cnt", 64'(frames_drop), 64'(exp_drop));
      check("data_consumed", 64'(drp[vt[i].port]), 64'(dwp[vt[i].port]));
      if (vt[i].fwd) drain_one();
      else check("no_desc", 64'(bus.ptr_sfifo_empty), 64'(1));
    end

    // Round-robin order: all ports loaded while held in reset.
    @(negedge clk);
    rstn = 1'b0;
    exp_fwd = 0;
    exp_drop = 0;
    repeat (2) @(negedge clk);
    for (int r = 0; r < 2; r++)
      for (int p = 0; p < NP; p++)
        push_frame(p, 2'b00, 20 + 3 * (r * NP + p), 1'b1, 16 + 3 * (r * NP + p));
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    wait_done(8, 2000);
    for (int i = 0; i < 8; i++) drain_one();
    check("rr_desc_left", 64'(exp_desc.size()), 64'(0));

    // Backpressure: ten max frames cross the threshold.
    n = exp_fwd + exp_drop;
    for (int i = 0; i < 10; i++) push_frame(i % NP, 2'b00, 1518, 1'b1, 1514);
    wait_done(n + 10, 20000);
    push_frame(2, 2'b00, 64, 1'b1, 60);
    repeat (100) @(negedge clk);
    check("bp_hold_ptr", 64'(prp[2]), 64'(pwp[2] - 1));
    check("bp_hold_fwd", 64'(frames_fwd), 64'(n + 10));
    drain_one();
    c = 0;
    while (prp[2] != pwp[2] && c < 4) begin
      @(negedge clk);
      c++;
    end
    check("bp_resume", 64'(prp[2]), 64'(pwp[2]));
    wait_done(n + 11, 2000);
    for (int i = 0; i < 10; i++) drain_one();
    check("bp_desc_left", 64'(exp_desc.size()), 64'(0));
    check("bp_ptr_empty", 64'(bus.ptr_sfifo_empty), 64'(1));

    // Reset in the middle of a data burst.
    push_frame(1, 2'b00, 200, 1'b0, 0);
    c = 0;
    while (bus.rx_data_fifo_rd == '0 && c < 100) begin
      @(negedge clk);
      c++;
    end
    check("mid_data_seen", 64'(bus.rx_data_fifo_rd), 64'(4'b0010));
    repeat (20) @(negedge clk);
    rstn = 1'b0;
    #1;
    check("mid_rst_ptr_rd", 64'(bus.rx_ptr_fifo_rd), 64'(0));
    check("mid_rst_data_rd", 64'(bus.rx_data_fifo_rd), 64'(0));
    check("mid_rst_ptr_empty", 64'(bus.ptr_sfifo_empty), 64'(1));
    check("mid_rst_fwd", 64'(frames_fwd), 64'(0));
    check("mid_rst_drop", 64'(frames_drop), 64'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/rx_mux_rr.md
Name: rx_mux_rr

Overview:
- Parametrised N-port ingress aggregator.
- Arbitrates between NUM_PORTS per-port receive queues. Each queue is a byte data FIFO plus a 16-bit frame descriptor FIFO.
- Copies one whole frame at a time into a shared byte data FIFO and a shared descriptor FIFO, both instantiated internally from sync_fifo. Feeds the switch core.
- Strips a configurable trailer (FCS), drops errored or runt frames, applies configurable backpressure and maintains frame statistics.

Parameters:
- NUM_PORTS, 4, number of ingress ports (2..8).
- ARB_MODE, 0, 0 = round-robin starting after last grant; 1 = fixed priority, lowest index wins.
- LEN_W, 11, width of descriptor length field.
- STRIP_BYTES, 4, trailing bytes removed from every forwarded frame.
- DATA_AW, 14, shared data FIFO address width (depth 2^DATA_AW bytes).
- PTR_AW, 5, shared descriptor FIFO address width.
- MAX_FRAME, 1518, worst-case frame bytes; sets backpressure threshold.

Ports:
- clk  in  1  clock
- rstn  in  1  reset
- rx_ptr_fifo_empty  in  NUM_PORTS  per-port descriptor FIFO empty
- rx_ptr_fifo_rd  out  NUM_PORTS  per-port descriptor read strobe, one-hot or zero
- rx_ptr_fifo_dout  in  16*NUM_PORTS  per-port descriptors; port i at [16i+15:16i]; [15:14] error, [LEN_W-1:0] length
- rx_data_fifo_rd  out  NUM_PORTS  per-port data read strobe, one-hot or zero
- rx_data_fifo_dout  in  8*NUM_PORTS  per-port data bytes
- sfifo_rd  in  1  shared data FIFO read
- sfifo_dout  out  8  shared data FIFO output
- ptr_sfifo_rd  in  1  shared descriptor FIFO read
- ptr_sfifo_dout  out  1+NUM_PORTS+LEN_W  descriptor {1'b0, one-hot source portmap, forwarded length}
- ptr_sfifo_empty  out  1  shared descriptor FIFO empty
- frames_fwd  out  32  forwarded frame count
- frames_drop  out  32  dropped frame count

Behaviour:
- Reset: asynchronous, active-low on rstn, clock clk. All strobes 0, state IDLE, rr_ptr 0, counters 0, internal FIFOs empty.
- Read latency: per-port FIFO dout is valid one cycle after its rd strobe.
- bp = (sfifo data_count > 2^DATA_AW - MAX_FRAME) | ptr_sfifo_full. bp is sampled only in IDLE; a frame in progress always completes.
- IDLE: if !bp and any port is non-empty, grant g is chosen as follows.
  - ARB_MODE 0: first non-empty port scanning rr_ptr, rr_ptr+1, ... mod NUM_PORTS.
  - ARB_MODE 1: lowest non-empty index.
  - Then pulse rx_ptr_fifo_rd[g] for 1 cycle and go to PTR_LAT.
- PTR_LAT: rr_ptr <= (g+1) mod NUM_PORTS; go to PTR_CAP.
- PTR_CAP: latch len = dout[LEN_W-1:0] and drop = dout[15] | dout[14] | (len <= STRIP_BYTES).
  - len == 0: count as drop, go to IDLE with no data read.
  - Otherwise go to DATA.
- DATA: rx_data_fifo_rd[g] is high for exactly len consecutive cycles. Byte k (0-based) is captured one cycle after its read. It is written to the shared data FIFO iff !drop and k < len - STRIP_BYTES. The stripped trailer is read and discarded. After the last byte is captured, go to DESC.
- DESC: one cycle.
  - If !drop: ptr_sfifo_wr = 1 with {0, onehot(g), len - STRIP_BYTES}, and frames_fwd += 1.
  - Else: frames_drop += 1.
  - Go to IDLE.
- Minimum per-frame overhead is 4 idle cycles between frames.
- Counters saturate at 2^32 - 1.
- Simultaneous requests are resolved only by the arbiter. An empty flag that rises during a frame has no effect.
- Reset mid-frame: everything is cleared immediately. Partially written shared-FIFO content is discarded, because the internal FIFOs also reset.

Test Plan:
- Single port 0 frame, len = 64, no error -> 60 bytes in sfifo equal to first 60 input bytes; descriptor {0, 4'b0001, 60}; frames_fwd = 1.
- All 4 ports each hold 2 frames, ARB_MODE 0 -> grant order 0,1,2,3,0,1,2,3. With ARB_MODE 1 -> order 0,0,1,1,2,2,3,3.
- Port 2 descriptor with bit 14 set, len = 100 -> 100 data reads issued, nothing written to sfifo or ptr_sfifo, frames_drop = 1; the next good frame is aligned correctly.
- len = 4 and len = 0 descriptors -> both dropped; len = 4 consumes 4 data bytes, len = 0 consumes none; frames_drop = 2.
- sfifo filled above 2^14 - 1518 -> no new ptr read while over threshold; an in-flight frame still completes; draining below threshold resumes arbitration within 1 cycle.
- Assert rstn low in middle of DATA -> all rd strobes 0 within the reset edge, ptr_sfifo_empty = 1, counters 0.
